// File: rtl/arc4_sched_if.sv
// Engine-side bundle: start/ready handshake plus the engine's s_mem request.
// The scheduler holds the master view; each engine holds the slave view.
interface arc4_sched_if;
  logic       en;
  logic       rdy;
  logic [7:0] addr;
  logic [7:0] wrdata;
  logic       wren;

  modport master (output en, input rdy, input addr, input wrdata, input wren);
  modport slave  (input en, output rdy, output addr, output wrdata, output wren);
endinterface

// File: rtl/arc4_sched.sv
// ARC4 pass sequencer: runs init -> ksa -> prga once per start and grants s_mem to the active engine.
// Define ARC4_PHASE_TIMEOUT_EN to add the per-phase watchdog, sticky err and the ERR state.
module arc4_sched #(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         rdy,
  output logic [2:0]   phase,
  output logic         err,
  arc4_sched_if.master init_bus,
  arc4_sched_if.master ksa_bus,
  arc4_sched_if.master prga_bus,
  output logic [7:0]   s_addr,
  output logic [7:0]   s_wrdata,
  output logic         s_wren
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INIT_GO  = 3'd1;
  localparam logic [2:0] S_INIT_RUN = 3'd2;
  localparam logic [2:0] S_KSA_GO   = 3'd3;
  localparam logic [2:0] S_KSA_RUN  = 3'd4;
  localparam logic [2:0] S_PRGA_GO  = 3'd5;
  localparam logic [2:0] S_PRGA_RUN = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       ack;
  logic       owner_rdy;
  logic       phase_active;
  logic       init_en_q;
  logic       ksa_en_q;
  logic       prga_en_q;

  assign phase_active = (state != S_IDLE) && (state != S_ERR);

  always_comb begin
    owner_rdy = 1'b0;
    case (state)
      S_INIT_GO, S_INIT_RUN: owner_rdy = init_bus.rdy;
      S_KSA_GO,  S_KSA_RUN:  owner_rdy = ksa_bus.rdy;
      S_PRGA_GO, S_PRGA_RUN: owner_rdy = prga_bus.rdy;
      default:               owner_rdy = 1'b0;
    endcase
  end

`ifdef ARC4_PHASE_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_expire;
  logic        go_entry;
  logic        err_q;

  assign wd_expire = phase_active && ((wd_cnt + 16'd1) == TIMEOUT);
  assign go_entry  = (state_next != state) &&
                     ((state_next == S_INIT_GO) || (state_next == S_KSA_GO) ||
                      (state_next == S_PRGA_GO));
`endif

  // A RUN phase only completes after the engine has been seen busy (ack) and then idle again.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (en) state_next = S_INIT_GO;
      S_INIT_GO:  if (owner_rdy) state_next = S_INIT_RUN;
      S_INIT_RUN: if (ack && owner_rdy) state_next = S_KSA_GO;
      S_KSA_GO:   if (owner_rdy) state_next = S_KSA_RUN;
      S_KSA_RUN:  if (ack && owner_rdy) state_next = S_PRGA_GO;
      S_PRGA_GO:  if (owner_rdy) state_next = S_PRGA_RUN;
      S_PRGA_RUN: if (ack && owner_rdy) state_next = S_IDLE;
`ifdef ARC4_PHASE_TIMEOUT_EN
      default:    state_next = S_ERR;
`else
      default:    state_next = S_IDLE;
`endif
    endcase
`ifdef ARC4_PHASE_TIMEOUT_EN
    if (wd_expire) state_next = S_ERR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ack       <= 1'b0;
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
    end else begin
      state     <= state_next;
      init_en_q <= (state == S_INIT_GO) && (state_next == S_INIT_RUN);
      ksa_en_q  <= (state == S_KSA_GO)  && (state_next == S_KSA_RUN);
      prga_en_q <= (state == S_PRGA_GO) && (state_next == S_PRGA_RUN);
      if (state_next != state)
        ack <= 1'b0;
      else if (!owner_rdy)
        ack <= 1'b1;
    end
  end

`ifdef ARC4_PHASE_TIMEOUT_EN
  // Watchdog counts cycles spent in one engine's GO+RUN; err stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      if (go_entry)
        wd_cnt <= 16'd0;
      else if (phase_active)
        wd_cnt <= wd_cnt + 16'd1;
      if (state_next == S_ERR)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  assign rdy          = (state == S_IDLE);
  assign phase        = state;
  assign init_bus.en  = init_en_q;
  assign ksa_bus.en   = ksa_en_q;
  assign prga_bus.en  = prga_en_q;

  // Grant follows the registered state only, so an owner change lands on the state edge.
  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (state)
      S_INIT_GO, S_INIT_RUN: begin
        s_addr   = init_bus.addr;
        s_wrdata = init_bus.wrdata;
        s_wren   = init_bus.wren;
      end
      S_KSA_GO, S_KSA_RUN: begin
        s_addr   = ksa_bus.addr;
        s_wrdata = ksa_bus.wrdata;
        s_wren   = ksa_bus.wren;
      end
      S_PRGA_GO, S_PRGA_RUN: begin
        s_addr   = prga_bus.addr;
        s_wrdata = prga_bus.wrdata;
        s_wren   = prga_bus.wren;
      end
      default: begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_sched.sv
// Self-checking bench for arc4_sched: engine models with programmable busy time, a timeline
// reference built from handshake latencies, a grant-mux vector table and randomized passes.
module tb_arc4_sched;

  localparam int TB_TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [2:0] phase;
  logic       err;
  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;

  arc4_sched_if init_if ();
  arc4_sched_if ksa_if ();
  arc4_sched_if prga_if ();

  arc4_sched #(.TIMEOUT(16'(TB_TIMEOUT))) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .phase    (phase),
    .err      (err),
    .init_bus (init_if),
    .ksa_bus  (ksa_if),
    .prga_bus (prga_if),
    .s_addr   (s_addr),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] phase;
    logic [2:0] ens;
  } exp_t;

  typedef struct {
    logic       iw; logic [7:0] ia; logic [7:0] id;
    logic       kw; logic [7:0] ka; logic [7:0] kd;
    logic       pw; logic [7:0] pa; logic [7:0] pd;
    logic       ew; logic [7:0] ea; logic [7:0] ed;
  } vec_t;

  exp_t sched[$];
  vec_t vecs[6];

  // Engine models: en drops rdy for busy[i] cycles; init rdy can also be held low by the bench.
  logic       init_hold;
  logic [2:0] m_rdy;
  int         m_cnt[3];
  int         busy[3];
  logic [2:0] eng_en;
  logic [7:0] b_addr[3];
  logic [7:0] b_data[3];
  logic       b_wren[3];

  assign eng_en = {prga_if.en, ksa_if.en, init_if.en};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_rdy[i] <= 1'b1;
        m_cnt[i] <= 0;
      end else if (eng_en[i]) begin
        m_rdy[i] <= 1'b0;
        m_cnt[i] <= busy[i] - 1;
      end else if (!m_rdy[i]) begin
        if (m_cnt[i] == 0) m_rdy[i] <= 1'b1;
        else               m_cnt[i] <= m_cnt[i] - 1;
      end
    end
  end

  assign init_if.rdy    = m_rdy[0] & ~init_hold;
  assign ksa_if.rdy     = m_rdy[1];
  assign prga_if.rdy    = m_rdy[2];
  assign init_if.addr   = b_addr[0];
  assign init_if.wrdata = b_data[0];
  assign init_if.wren   = b_wren[0];
  assign ksa_if.addr    = b_addr[1];
  assign ksa_if.wrdata  = b_data[1];
  assign ksa_if.wren    = b_wren[1];
  assign prga_if.addr   = b_addr[2];
  assign prga_if.wrdata = b_data[2];
  assign prga_if.wren   = b_wren[2];

  task applyStimulus(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    b_wren[i] = we;
    b_addr[i] = a;
    b_data[i] = d;
  endtask

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Timeline per pass: GO lasts until the engine is ready, RUN lasts busy+2 cycles
  // (en cycle, busy cycles seen low, one cycle seen high again), then IDLE.
  function automatic void buildSched(input int h, input int bi, input int bk, input int bp,
                                     input int cap);
    int   b[3];
    exp_t e;
    b[0] = bi; b[1] = bk; b[2] = bp;
    sched.delete();
    for (int x = 0; x < 3; x++) begin
      int g;
      int go_len;
      g = sched.size();
      go_len = (x == 0) ? h + 1 : 1;
      for (int k = 0; k < go_len + b[x] + 2; k++) begin
        if (sched.size() >= cap) return;
`ifdef ARC4_PHASE_TIMEOUT_EN
        if (sched.size() - g >= TB_TIMEOUT) begin
          while (sched.size() < cap) begin
            e.phase = 3'd7;
            e.ens   = 3'd0;
            sched.push_back(e);
          end
          return;
        end
`endif
        if (k < go_len) begin
          e.phase = 3'(2 * x + 1);
          e.ens   = 3'd0;
        end else begin
          e.phase = 3'(2 * x + 2);
          e.ens   = (k == go_len) ? 3'(1 << x) : 3'd0;
        end
        sched.push_back(e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (sched.size() >= cap) return;
      e.phase = 3'd0;
      e.ens   = 3'd0;
      sched.push_back(e);
    end
  endfunction

  task checkCycle(input int t, input exp_t e);
    int         o;
    logic       ew;
    logic [7:0] ea;
    logic [7:0] ed;
    o = (e.phase == 3'd1 || e.phase == 3'd2) ? 0 :
        (e.phase == 3'd3 || e.phase == 3'd4) ? 1 :
        (e.phase == 3'd5 || e.phase == 3'd6) ? 2 : -1;
    if (o < 0) begin
      ew = 1'b0; ea = 8'd0; ed = 8'd0;
    end else begin
      ew = b_wren[o]; ea = b_addr[o]; ed = b_data[o];
    end
    checkOutput($sformatf("phase@%0d", t), phase, e.phase);
    checkOutput($sformatf("rdy@%0d", t), rdy, e.phase == 3'd0);
    checkOutput($sformatf("err@%0d", t), err, e.phase == 3'd7);
    checkOutput($sformatf("en_pulses@%0d", t), eng_en, e.ens);
    checkOutput($sformatf("s_wren@%0d", t), s_wren, ew);
    checkOutput($sformatf("s_addr@%0d", t), s_addr, ea);
    checkOutput($sformatf("s_wrdata@%0d", t), s_wrdata, ed);
  endtask

  task automatic runPass(input int h, input int bi, input int bk, input int bp,
                         input int g1, input int g2, input int rst_at, input int cap);
    int   seen[3];
    int   want[3];
    int   rise_p;
    int   rise_r;
    logic prev_p;
    logic prev_r;
    busy[0] = bi; busy[1] = bk; busy[2] = bp;
    buildSched(h, bi, bk, bp, (rst_at >= 0) ? rst_at + 4 : cap);
    if (rst_at >= 0) begin
      while (sched.size() < rst_at + 4) sched.push_back('{3'd0, 3'd0});
      for (int t = rst_at + 1; t < sched.size(); t++) begin
        sched[t].phase = 3'd0;
        sched[t].ens   = 3'd0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      seen[i] = 0;
      want[i] = 0;
    end
    foreach (sched[t])
      for (int i = 0; i < 3; i++) if (sched[t].ens[i]) want[i]++;
    rise_p = -100; rise_r = -100; prev_p = 1'b1; prev_r = 1'b1;

    @(posedge clk);
    #1;
    en = 1'b1;
    init_hold = (h > 0);
    @(posedge clk);
    for (int t = 0; t < sched.size(); t++) begin
      #1;
      en = (t == g1) || (t == g2);
      rst = (t == rst_at);
      init_hold = (t < h);
      for (int i = 0; i < 3; i++)
        applyStimulus(i, 1'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      checkCycle(t, sched[t]);
      for (int i = 0; i < 3; i++) if (eng_en[i]) seen[i]++;
      if (prga_if.rdy && !prev_p) rise_p = t;
      if (rdy && !prev_r) rise_r = t;
      prev_p = prga_if.rdy;
      prev_r = rdy;
      @(posedge clk);
    end
    #1;
    en = 1'b0;
    rst = 1'b0;
    init_hold = 1'b0;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("en_count[%0d]", i), seen[i], want[i]);
    if (rst_at < 0 && sched[sched.size() - 1].phase == 3'd0)
      checkOutput("rdy_after_prga_rdy", rise_r - rise_p, 1);
  endtask

  task resetDut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    en = 1'b0;
    init_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_phase", phase, 3'd0);
    checkOutput("reset_rdy", rdy, 1'b1);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_en", eng_en, 3'd0);
    checkOutput("reset_s_wren", s_wren, 1'b0);
    checkOutput("reset_s_addr", s_addr, 8'd0);
    checkOutput("reset_s_wrdata", s_wrdata, 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h10, 8'h55, 1'b1, 8'hAA, 8'h66, 1'b1, 8'hBB, 8'h77, 1'b1, 8'h10, 8'h55};
    vecs[1] = '{1'b0, 8'h10, 8'h55, 1'b1, 8'hAA, 8'h66, 1'b1, 8'hBB, 8'h77, 1'b0, 8'h10, 8'h55};
    vecs[2] = '{1'b1, 8'hFF, 8'h00, 1'b0, 8'hAA, 8'h11, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hAA, 8'hFF, 1'b1, 8'hAA, 8'hFF, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'h01, 8'h02, 1'b1, 8'hAA, 8'h03, 1'b0, 8'h04, 8'h05, 1'b1, 8'h01, 8'h02};
    vecs[5] = '{1'b1, 8'h3C, 8'hC3, 1'b1, 8'hAA, 8'hAA, 1'b1, 8'hAA, 8'hAA, 1'b1, 8'h3C, 8'hC3};

    rst = 1'b1;
    en = 1'b0;
    init_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      busy[i] = 1;
      applyStimulus(i, 1'b1, 8'h5A, 8'hA5);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("por_phase", phase, 3'd0);
    checkOutput("por_rdy", rdy, 1'b1);
    checkOutput("por_en", eng_en, 3'd0);
    checkOutput("por_s_wren", s_wren, 1'b0);
    checkOutput("por_s_addr", s_addr, 8'd0);
    checkOutput("por_s_wrdata", s_wrdata, 8'd0);
    checkOutput("por_err", err, 1'b0);
    rst = 1'b0;

    $display("[TB] directed pass 256/768/300 with init hold and stray en");
    runPass(5, 256, 768, 300, 10, 50, -1, 5000);

    $display("[TB] reset during KSA_RUN, then fresh pass");
    runPass(0, 256, 768, 300, -1, -1, 400, 5000);
    runPass(0, 3, 4, 5, -1, -1, -1, 5000);

    $display("[TB] en together with rst");
    @(posedge clk);
    #1;
    en = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("enrst_phase@%0d", k), phase, 3'd0);
      checkOutput($sformatf("enrst_en@%0d", k), eng_en, 3'd0);
      @(posedge clk);
    end

    $display("[TB] grant table during INIT_RUN");
    busy[0] = 1000; busy[1] = 5; busy[2] = 5;
    @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (2) @(posedge clk);
    for (int v = 0; v < 6; v++) begin
      #1;
      applyStimulus(0, vecs[v].iw, vecs[v].ia, vecs[v].id);
      applyStimulus(1, vecs[v].kw, vecs[v].ka, vecs[v].kd);
      applyStimulus(2, vecs[v].pw, vecs[v].pa, vecs[v].pd);
      @(negedge clk);
      checkOutput($sformatf("tbl_phase[%0d]", v), phase, 3'd2);
      checkOutput($sformatf("tbl_s_wren[%0d]", v), s_wren, vecs[v].ew);
      checkOutput($sformatf("tbl_s_addr[%0d]", v), s_addr, vecs[v].ea);
      checkOutput($sformatf("tbl_s_wrdata[%0d]", v), s_wrdata, vecs[v].ed);
      checkOutput($sformatf("tbl_no_aa_write[%0d]", v), s_wren && (s_addr == 8'hAA), 1'b0);
      @(posedge clk);
    end
    resetDut();

    $display("[TB] ksa engine never returns ready");
    runPass(0, 10, 1000000, 1, -1, -1, -1, TB_TIMEOUT + 40);
    resetDut();

    $display("[TB] randomized passes");
    for (int p = 0; p < 20; p++) begin
      int h, bi, bk, bp, len, g1, g2;
      h  = int'($urandom_range(4, 0));
      bi = int'($urandom_range(30, 1));
      bk = int'($urandom_range(30, 1));
      bp = int'($urandom_range(30, 1));
      len = h + 1 + bi + 2 + 1 + bk + 2 + 1 + bp + 2;
      g1 = int'($urandom_range(len - 1, 0));
      g2 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(len - 1, 0)) : -1;
      runPass(h, bi, bk, bp, g1, g2, -1, len + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer and S-memory arbiter for one ARC4 decrypt pass.
- On a single start handshake it runs the init, ksa and prga engines in order, pulsing each engine's en and waiting for its rdy.
- It grants the single-port s_mem address/data/wren port to exactly one engine at a time.
- It sits between the task top level (KEY/SW/LEDR) and the engine instances, replacing per-task ad hoc en-pulse FSMs.

Parameters:
- TIMEOUT, 4096, per-phase watchdog limit in clk cycles; 16-bit; used only when ARC4_PHASE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  1 = idle, ready to accept en.
- phase  out  3  current state encoding, for LEDR.
- err  out  1  sticky watchdog error; constant 0 without macro.
- init_en / ksa_en / prga_en  out  1 each  one-cycle start pulses to the engines.
- init_rdy / ksa_rdy / prga_rdy  in  1 each  engine idle/ready flags.
- init_addr, init_wrdata / ksa_addr, ksa_wrdata / prga_addr, prga_wrdata  in  8 each  engine memory requests.
- init_wren / ksa_wren / prga_wren  in  1 each  engine write enables.
- s_addr  out  8  to s_mem address.
- s_wrdata  out  8  to s_mem data.
- s_wren  out  1  to s_mem wren.
- s_mem q is fanned out directly to the engines and does not pass through this block.

Behaviour:
- Reset is synchronous; rst wins over all other inputs.
- On the cycle after rst is sampled high:
  - state=IDLE, rdy=1, all *_en=0, s_wren=0, s_addr=0, s_wrdata=0, phase=0, err=0.
- States and phase codes: IDLE(0), INIT_GO(1), INIT_RUN(2), KSA_GO(3), KSA_RUN(4), PRGA_GO(5), PRGA_RUN(6), ERR(7).
- IDLE:
  - rdy=1.
  - en=1 -> INIT_GO next cycle; rdy=0 from that cycle.
  - en while rdy=0 is ignored; no queuing.
- X_GO (X = init/ksa/prga):
  - Wait for X_rdy=1.
  - In the cycle X_rdy=1 is sampled, assert X_en=1 for exactly that one cycle, then -> X_RUN.
  - X_en is registered, never combinational from X_rdy.
- X_RUN uses a one-bit ack flag, cleared on entry:
  - Set the flag when X_rdy=0 is observed.
  - Once the flag is set, X_rdy=1 -> next phase: INIT->KSA_GO, KSA->PRGA_GO, PRGA->IDLE.
  - An engine that never drops rdy stalls the state in X_RUN (watchdog only with the macro).
- Grant rule:
  - owner = init in INIT_GO/INIT_RUN, ksa in KSA_*, prga in PRGA_*; none in IDLE/ERR.
  - s_addr/s_wrdata/s_wren = owner's signals, combinational from registered state (0-cycle mux latency).
  - No owner -> s_wren=0, s_addr=0, s_wrdata=0.
  - Non-owner wren never reaches s_mem.
- Owner change happens on the state-register edge, so the previous owner's last-cycle write commits and the new owner's first access lands the following cycle.
- Full pass returns to IDLE with rdy=1; a new en starts a fresh pass at INIT_GO.
- Reset mid-pass:
  - Next cycle is IDLE; s_wren=0 immediately that cycle.
  - Engines are reset via their own reset, which the top level ties to the same source.
- Simultaneous en and rst: rst wins; state=IDLE, request dropped.

Optional Feature:
- Macro ARC4_PHASE_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on entry to each X_GO; increments every cycle in X_GO/X_RUN.
  - Reaching TIMEOUT -> ERR; err=1 sticky; s_wren=0; rdy=0.
  - ERR is left only by rst.
- Undefined:
  - No counter, no ERR state (phase 7 unreachable); err tied to 0; phases wait indefinitely.

Test Plan:
- Reset then en=1 for one cycle, engine models with 256/768/300-cycle busy times -> init_en, ksa_en and prga_en each pulse once, in that order; phase sequence 1,2,3,4,5,6,0; rdy returns to 1 exactly one cycle after prga_rdy rises.
- During INIT_RUN, drive ksa_wren=1, ksa_addr=8'hAA and init_wren=1, init_addr=8'h10 -> s_wren=1, s_addr=8'h10; no write to 8'hAA ever reaches s_mem.
- Hold init_rdy=0 for 5 cycles while in INIT_GO -> init_en stays 0 and is asserted for exactly one cycle on the cycle init_rdy=1 is sampled.
- Assert rst during KSA_RUN at cycle 400 -> next cycle phase=0, rdy=1, s_wren=0, all *_en=0; a following en restarts from INIT_GO.
- en pulses at cycles 10 and 50 of a busy pass -> both ignored; exactly one init_en pulse per pass; en together with rst -> no pass started.
- With ARC4_PHASE_TIMEOUT_EN, TIMEOUT=100, ksa_rdy stuck low -> entry into ERR exactly 100 cycles after KSA_GO entry, err=1, phase=7, s_wren=0; held until rst. Without the macro -> stays in KSA_RUN, err=0.
